snap_capture_ctrl: RTL and testbench



---
 rtl/snap_pkg.sv | 25 ++
 rtl/snap_dpram.sv | 29 ++
 rtl/snap_capture_ctrl.sv | 156 +++++++++++++++
 tb/tb_snap_capture_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snap_pkg.sv
// Shared state codes and sizing helpers for the snapshot capture engine.
package snap_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_PRE       = 3'd1;
    localparam state_t ST_WAIT_TRIG = 3'd2;
    localparam state_t ST_POST      = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int sub_w_of(input int data_w, input int bus_w);
        return (data_w > bus_w) ? $clog2(data_w / bus_w) : 0;
    endfunction

    // Pre-trigger history must leave at least the trigger sample itself in the buffer.
    function automatic int clamp_pre_len(input int pre_len, input int depth);
        return (pre_len > depth - 1) ? depth - 1 : pre_len;
    endfunction

endpackage

// File: rtl/snap_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module snap_dpram
    import snap_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:depth_of(ADDR_W)-1];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture engine: arm/trigger sequencing with optional circular
// pre-trigger history, plus a two-stage word-addressed readback path.
module snap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int  DATA_W = 64,
    parameter int  ADDR_W = 9,
    parameter int  BUS_W  = 32,
    localparam int SUB_W  = sub_w_of(DATA_W, BUS_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_valid,
    input  logic                    arm,
    input  logic                    trig,
    input  logic                    circ_mode,
    input  logic [ADDR_W-1:0]       pre_len,
    input  logic                    rd_en,
    input  logic [ADDR_W+SUB_W-1:0] rd_addr,
    output logic [BUS_W-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       trig_addr
);

    localparam int DEPTH = depth_of(ADDR_W);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [ADDR_W:0]   post_cnt;
    logic [ADDR_W:0]   post_next;
    logic [ADDR_W:0]   post_total;
    logic [ADDR_W-1:0] pre_len_q;
    logic [ADDR_W-1:0] pre_clamped;
    logic              circ_q;
    logic              we;
    logic [DATA_W-1:0] ram_q;
    logic [BUS_W-1:0]  word_sel;
    logic              rd_v1;

    assign next_ptr    = wr_ptr + ADDR_W'(1);
    assign post_next   = post_cnt + (ADDR_W+1)'(1);
    assign post_total  = (ADDR_W+1)'(DEPTH) - {1'b0, pre_len_q};
    assign pre_clamped = ADDR_W'(clamp_pre_len(int'(pre_len), DEPTH));

    // One-shot mode discards samples until the trigger; the trigger sample itself is always stored.
    assign we = din_valid && !arm &&
                ((state == ST_PRE) || (state == ST_POST) ||
                 ((state == ST_WAIT_TRIG) && (circ_q || trig)));

    assign busy = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            post_cnt  <= '0;
            pre_len_q <= '0;
            circ_q    <= 1'b0;
            trig_addr <= '0;
        end else if (arm) begin
            wr_ptr    <= '0;
            post_cnt  <= '0;
            circ_q    <= circ_mode;
            pre_len_q <= circ_mode ? pre_clamped : '0;
            if (!circ_mode || (pre_clamped == '0)) begin
                state <= ST_WAIT_TRIG;
            end else begin
                state <= ST_PRE;
            end
        end else if (din_valid) begin
            case (state)
                ST_PRE: begin
                    wr_ptr <= next_ptr;
                    if (next_ptr == pre_len_q) begin
                        state <= ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig) begin
                        wr_ptr    <= next_ptr;
                        trig_addr <= wr_ptr;
                        post_cnt  <= (ADDR_W+1)'(1);
                        // Maximum pre-trigger history leaves room for the trigger sample only.
                        state     <= (post_total == (ADDR_W+1)'(1)) ? ST_DONE : ST_POST;
                    end else if (circ_q) begin
                        wr_ptr <= next_ptr;
                    end
                end
                ST_POST: begin
                    wr_ptr   <= next_ptr;
                    post_cnt <= post_next;
                    if (post_next == post_total) begin
                        state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    snap_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_en),
        .raddr (rd_addr[ADDR_W+SUB_W-1:SUB_W]),
        .rdata (ram_q)
    );

    // Sub-word 0 selects the most significant slice of the sample.
    generate
        if (SUB_W == 0) begin : g_single
            always_comb begin
                word_sel = ram_q[BUS_W-1:0];
            end
        end else begin : g_multi
            logic [SUB_W-1:0] sub_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sub_q <= '0;
                end else begin
                    sub_q <= rd_addr[SUB_W-1:0];
                end
            end

            always_comb begin
                word_sel = ram_q[DATA_W-1 - int'(sub_q)*BUS_W -: BUS_W];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_v1    <= rd_en;
            rd_valid <= rd_v1;
            if (rd_v1) begin
                rd_data <= word_sel;
            end
        end
    end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed and randomized bench for snap_capture_ctrl; expected RAM images are
// derived from the arm/trigger rules with plain index arithmetic.
module tb_snap_capture_ctrl;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int BUS_W  = 32;
    localparam int SUB_W  = 1;
    localparam int DEPTH  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [DATA_W-1:0]       din = '0;
    logic                    din_valid = 1'b0;
    logic                    arm = 1'b0;
    logic                    trig = 1'b0;
    logic                    circ_mode = 1'b0;
    logic [ADDR_W-1:0]       pre_len = '0;
    logic                    rd_en = 1'b0;
    logic [ADDR_W+SUB_W-1:0] rd_addr = '0;
    logic [BUS_W-1:0]        rd_data;
    logic                    rd_valid;
    logic                    busy;
    logic                    done;
    logic [ADDR_W-1:0]       trig_addr;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [DATA_W-1:0] vals [0:1023];
    logic [DATA_W-1:0] mram [0:DEPTH-1];

    snap_capture_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BUS_W  (BUS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .arm       (arm),
        .trig      (trig),
        .circ_mode (circ_mode),
        .pre_len   (pre_len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .trig_addr (trig_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [63:0] sample_val();
        return {32'hC0DE0000 + 32'(cycle), 32'(cycle)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs are driven on the falling edge and take effect at the next rising edge.
    task automatic applyStimulus(input logic a, input logic v, input logic t, input logic [63:0] d);
        arm       = a;
        din_valid = v;
        trig      = t;
        din       = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkReadback(input string name);
        logic [63:0] s;
        din_valid = 1'b0;
        trig      = 1'b0;
        arm       = 1'b0;
        for (int k = 0; k <= 2*DEPTH + 2; k++) begin
            if (k >= 2) begin
                if (k - 2 < 2*DEPTH) begin
                    s = mram[(k-2)/2];
                    checkOutput({name, ".rd_valid"}, 64'(rd_valid), 64'(1));
                    checkOutput($sformatf("%s.rd_data[%0d]", name, k-2), 64'(rd_data),
                                ((k-2) % 2 == 0) ? 64'(s[63:32]) : 64'(s[31:0]));
                end else begin
                    checkOutput({name, ".rd_valid_end"}, 64'(rd_valid), 64'(0));
                end
            end
            rd_en   = (k < 2*DEPTH);
            rd_addr = (ADDR_W+SUB_W)'(k);
            @(posedge clk);
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    // gap: 0 = every cycle valid, 1 = alternate cycles, 2 = random.
    task automatic runCapture(input string name, input logic circ, input int pl, input int gap,
                              input int t1, input int t2, input int rearm_n);
        int   idx = 0;
        int   j = -1;
        int   budget = 0;
        int   plx;
        bit   rearmed = 0;
        bit   fin = 0;
        logic v;
        logic t;
        logic [63:0] d;
        plx       = circ ? pl : 0;
        circ_mode = circ;
        pre_len   = ADDR_W'(pl);
        applyStimulus(1'b1, 1'b0, 1'b0, sample_val());
        checkOutput({name, ".busy_arm"}, 64'(busy), 64'(1));
        checkOutput({name, ".done_arm"}, 64'(done), 64'(0));
        while (!fin) begin
            budget++;
            if (budget > 400) begin
                checkOutput({name, ".timeout"}, 64'(done), 64'(1));
                break;
            end
            if (!rearmed && rearm_n >= 0 && j >= 0 && idx == j + rearm_n) begin
                applyStimulus(1'b1, 1'b1, 1'b1, sample_val());
                rearmed = 1;
                idx = 0;
                j = -1;
                checkOutput({name, ".rearm_done"}, 64'(done), 64'(0));
                checkOutput({name, ".rearm_busy"}, 64'(busy), 64'(1));
            end else begin
                case (gap)
                    0:       v = 1'b1;
                    1:       v = (budget % 2 == 0);
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                t = v ? (idx == t1 || idx == t2) : 1'($urandom_range(0, 1));
                d = sample_val();
                applyStimulus(1'b0, v, t, d);
                if (v) begin
                    vals[idx] = d;
                    if (j < 0 && t && (!circ || idx >= pl)) j = idx;
                    idx++;
                end
                fin = (j >= 0) && (idx >= j + DEPTH - plx);
                checkOutput({name, ".done"}, 64'(done), 64'(fin));
                checkOutput({name, ".busy"}, 64'(busy), 64'(!fin));
            end
        end
        if (j >= 0) begin
            for (int i = j - plx; i <= j + DEPTH - plx - 1; i++) begin
                mram[circ ? (i % DEPTH) : (i - j)] = vals[i];
            end
            checkOutput({name, ".trig_addr"}, 64'(trig_addr), circ ? 64'(j % DEPTH) : 64'(0));
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, sample_val());
            checkOutput({name, ".done_hold"}, 64'(done), 64'(1));
            checkOutput({name, ".busy_hold"}, 64'(busy), 64'(0));
        end
        checkReadback(name);
    endtask

    initial begin
        int   r_pl;
        logic r_circ;

        $display("[TB] reset state");
        #2;
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.done", 64'(done), 64'(0));
        checkOutput("reset.rd_valid", 64'(rd_valid), 64'(0));
        checkOutput("reset.trig_addr", 64'(trig_addr), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] one-shot capture");
        runCapture("oneshot", 1'b0, 0, 0, 5, -1, -1);

        $display("[TB] circular capture with pre-trigger");
        runCapture("circ", 1'b1, 4, 0, 20, -1, -1);

        $display("[TB] early trigger ignored during pre-trigger fill");
        runCapture("early", 1'b1, 6, 2, 2, 9, -1);

        $display("[TB] one-shot with valid gaps");
        runCapture("gaps", 1'b0, 0, 1, 4, -1, -1);

        $display("[TB] re-arm during post-trigger");
        runCapture("rearm", 1'b0, 0, 0, 3, -1, 5);

        $display("[TB] maximum pre-trigger history");
        runCapture("maxpre", 1'b1, 15, 0, 15, -1, -1);

        for (int n = 0; n < 4; n++) begin
            r_circ = 1'($urandom_range(0, 1));
            r_pl   = $urandom_range(0, DEPTH - 1);
            $display("[TB] random capture %0d circ=%0d pre_len=%0d", n, r_circ, r_pl);
            runCapture($sformatf("rand%0d", n), r_circ, r_pl, 2,
                       $urandom_range(0, r_pl + 3), r_pl + $urandom_range(0, 8), -1);
        end

        $display("[TB] circular capture before reset test");
        runCapture("circ2", 1'b1, 4, 0, 21, -1, -1);

        $display("[TB] reset mid-capture");
        circ_mode = 1'b0;
        pre_len   = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, sample_val());
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, sample_val());
        checkOutput("midrst.busy_before", 64'(busy), 64'(1));
        din_valid = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.busy", 64'(busy), 64'(0));
        checkOutput("midrst.done", 64'(done), 64'(0));
        checkOutput("midrst.rd_valid", 64'(rd_valid), 64'(0));
        checkOutput("midrst.trig_addr", 64'(trig_addr), 64'(0));
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, sample_val());
        checkOutput("midrst.no_rearm_busy", 64'(busy), 64'(0));
        checkOutput("midrst.no_rearm_done", 64'(done), 64'(0));
        checkReadback("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
